// File: rtl/lift_hall_pkg.sv
// Shared constants and helpers for the lift motor Hall feedback decoder.
// Optional feature macro used by this slice: LIFT_HALL_IRQ_EN.
package lift_hall_pkg;

  // Register indices relative to ADDR_BASE
  localparam logic [1:0] REG_POS    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // Fault codes reported in the status register
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_INVALID = 2'b01;
  localparam logic [1:0] FLT_SEQ     = 2'b10;

  localparam logic [2:0] SECTOR_NONE = 3'd0;

  // Hall code {C,B,A} to commutation sector; 000 and 111 map to 0 (invalid)
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] sec;
    case (code)
      3'b001:  sec = 3'd1;
      3'b011:  sec = 3'd2;
      3'b010:  sec = 3'd3;
      3'b110:  sec = 3'd4;
      3'b100:  sec = 3'd5;
      3'b101:  sec = 3'd6;
      default: sec = 3'd0;
    endcase
    return sec;
  endfunction

  // Sector reached by one forward step (6 wraps to 1)
  function automatic logic [2:0] sector_next(input logic [2:0] sec);
    return (sec == 3'd6) ? 3'd1 : (sec + 3'd1);
  endfunction

  // Sector reached by one reverse step (1 wraps to 6)
  function automatic logic [2:0] sector_prev(input logic [2:0] sec);
    return (sec == 3'd1) ? 3'd6 : (sec - 3'd1);
  endfunction

endpackage

// File: rtl/lift_hall_decoder_filter.sv
// Hall input conditioning: two-flop synchronizer followed by a stability
// filter that only accepts a code after FILT_LEN identical samples.
// accept_o pulses for one cycle whenever code_o takes a new value.
module hall_sync_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] hall_i,
  input  logic       filter_en_i,
  output logic [2:0] code_o,
  output logic       accept_o
);

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  logic [2:0] sync1_q, sync2_q;
  logic [2:0] cand_q, cand_d;
  logic [2:0] code_q, code_d;
  logic [3:0] run_q, run_d;
  logic       accept_q, accept_d;

  // Bring the asynchronous Hall pins into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
    end
  end

  // Count identical consecutive samples and decide when a new code is accepted.
  always_comb begin
    cand_d   = sync2_q;
    run_d    = run_q;
    code_d   = code_q;
    accept_d = 1'b0;
    if (sync2_q == cand_q) begin
      if (run_q < FILT_LEN_C) begin
        run_d = run_q + 4'd1;
      end else begin
        run_d = run_q;
      end
    end else begin
      run_d = 4'd1;
    end
    if (filter_en_i) begin
      if ((run_d >= FILT_LEN_C) && (sync2_q != code_q)) begin
        code_d   = sync2_q;
        accept_d = 1'b1;
      end else begin
        code_d   = code_q;
        accept_d = 1'b0;
      end
    end else begin
      if (sync2_q != code_q) begin
        code_d   = sync2_q;
        accept_d = 1'b1;
      end else begin
        code_d   = code_q;
        accept_d = 1'b0;
      end
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_q   <= 3'b000;
      run_q    <= 4'd0;
      code_q   <= 3'b000;
      accept_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      run_q    <= run_d;
      code_q   <= code_d;
      accept_q <= accept_d;
    end
  end

  assign code_o   = code_q;
  assign accept_o = accept_q;

endmodule

// File: rtl/lift_hall_decoder.sv
// Lift motor Hall feedback: sector decode, direction, signed position,
// step period, stall and fault tracking, with an OPB register window.
// Optional macro LIFT_HALL_IRQ_EN adds the HALL_IRQ output and status bit 31.
module lift_hall_decoder
  import lift_hall_pkg::*;
#(
  parameter int unsigned FILT_LEN  = 4,
  parameter logic [31:0] STALL_MAX = 32'h00FF_FFFF,
  parameter logic [2:0]  ADDR_BASE = 3'h4
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [2:0]  HALL_IN,
  input  logic [31:0] LIFT_ADDR,
  input  logic [31:0] LIFT_MOT_DI,
  input  logic        LIFT_MOT_WE,
  input  logic        LIFT_MOT_RE,
  output logic [31:0] HALL_DO,
  output logic [2:0]  HALL_SECTOR,
  output logic        HALL_DIR,
  output logic        HALL_FAULT
`ifdef LIFT_HALL_IRQ_EN
  ,
  output logic        HALL_IRQ
`endif
);

  logic [2:0]  filt_code_s;
  logic        filt_acc_s;
  logic [2:0]  new_sec_s;
  logic        inv_s, evt_s, load_s, fwd_s, rev_s, seq_s;
  logic [2:0]  idx_s;
  logic [1:0]  reg_idx_s;
  logic        sel_s, ctrl_wr_s, clr_pos_s, clr_flt_s;
  logic [31:0] status_s;
  logic        unused_bits_s;

  logic [2:0]  sector_q, sector_d;
  logic        dir_q, dir_d;
  logic [31:0] pos_q, pos_d;
  logic        fault_q, fault_d;
  logic [1:0]  fcode_q, fcode_d;
  logic [7:0]  serr_q, serr_d, serr_base_s;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] period_q, period_d;
  logic        stall_q, stall_d;
  logic        filter_en_q, filter_en_d;

  hall_sync_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk_i       (OPB_CLK),
    .rst_i       (OPB_RST),
    .hall_i      (HALL_IN),
    .filter_en_i (filter_en_q),
    .code_o      (filt_code_s),
    .accept_o    (filt_acc_s)
  );

  // Address window: only the low three address bits are decoded.
  assign idx_s     = LIFT_ADDR[2:0] - ADDR_BASE;
  assign sel_s     = ~idx_s[2];
  assign reg_idx_s = idx_s[1:0];
  assign ctrl_wr_s = LIFT_MOT_WE & sel_s & (reg_idx_s == REG_CTRL);
  assign clr_pos_s = ctrl_wr_s & LIFT_MOT_DI[0];
  assign clr_flt_s = ctrl_wr_s & LIFT_MOT_DI[1];
  assign unused_bits_s = ^{LIFT_ADDR[31:3], LIFT_MOT_DI[31:3]};

  // Classify each accepted code: invalid, first load, forward, reverse or skip.
  assign new_sec_s = hall_to_sector(filt_code_s);
  assign inv_s  = filt_acc_s & (new_sec_s == SECTOR_NONE);
  assign evt_s  = filt_acc_s & (new_sec_s != SECTOR_NONE) & (new_sec_s != sector_q);
  assign load_s = evt_s & (sector_q == SECTOR_NONE);
  assign fwd_s  = evt_s & ~load_s & (new_sec_s == sector_next(sector_q));
  assign rev_s  = evt_s & ~load_s & (new_sec_s == sector_prev(sector_q));
  assign seq_s  = evt_s & ~load_s & ~fwd_s & ~rev_s;

  // Next-state for sector, direction, position, faults, period and stall.
  always_comb begin
    sector_d    = evt_s ? new_sec_s : sector_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    fault_d     = fault_q;
    fcode_d     = fcode_q;
    serr_base_s = serr_q;
    serr_d      = serr_q;
    per_cnt_d   = per_cnt_q;
    period_d    = period_q;
    stall_d     = stall_q;
    filter_en_d = ctrl_wr_s ? LIFT_MOT_DI[2] : filter_en_q;

    if (fwd_s) begin
      dir_d = 1'b1;
    end else if (rev_s) begin
      dir_d = 1'b0;
    end else begin
      dir_d = dir_q;
    end

    // A position clear beats a step landing in the same cycle.
    if (clr_pos_s) begin
      pos_d = 32'h0000_0000;
    end else if (fwd_s) begin
      pos_d = pos_q + 32'd1;
    end else if (rev_s) begin
      pos_d = pos_q - 32'd1;
    end else begin
      pos_d = pos_q;
    end

    // A newly detected fault survives a simultaneous fault clear.
    if (inv_s) begin
      fault_d = 1'b1;
      fcode_d = FLT_INVALID;
    end else if (seq_s) begin
      fault_d = 1'b1;
      fcode_d = FLT_SEQ;
    end else if (clr_flt_s) begin
      fault_d = 1'b0;
      fcode_d = FLT_NONE;
    end else begin
      fault_d = fault_q;
      fcode_d = fcode_q;
    end

    if (clr_flt_s) begin
      serr_base_s = 8'h00;
    end else begin
      serr_base_s = serr_q;
    end
    if (seq_s && (serr_base_s != 8'hFF)) begin
      serr_d = serr_base_s + 8'd1;
    end else begin
      serr_d = serr_base_s;
    end

    if (evt_s) begin
      per_cnt_d = 32'h0000_0000;
      period_d  = per_cnt_q + 32'd1;
    end else begin
      period_d = period_q;
      if (per_cnt_q < STALL_MAX) begin
        per_cnt_d = per_cnt_q + 32'd1;
      end else begin
        per_cnt_d = per_cnt_q;
      end
    end

    if (fwd_s || rev_s) begin
      stall_d = 1'b0;
    end else if (per_cnt_d == STALL_MAX) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Decoder state registers.
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      sector_q    <= SECTOR_NONE;
      dir_q       <= 1'b0;
      pos_q       <= 32'h0000_0000;
      fault_q     <= 1'b0;
      fcode_q     <= FLT_NONE;
      serr_q      <= 8'h00;
      per_cnt_q   <= 32'h0000_0000;
      period_q    <= 32'h0000_0000;
      stall_q     <= 1'b0;
      filter_en_q <= 1'b1;
    end else begin
      sector_q    <= sector_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      fault_q     <= fault_d;
      fcode_q     <= fcode_d;
      serr_q      <= serr_d;
      per_cnt_q   <= per_cnt_d;
      period_q    <= period_d;
      stall_q     <= stall_d;
      filter_en_q <= filter_en_d;
    end
  end

`ifdef LIFT_HALL_IRQ_EN
  logic irq_q, irq_d, fault_dly_q, stall_dly_q;

  // Interrupt level: set on a rising fault or stall, cleared by a fault clear.
  always_comb begin
    if ((fault_q && !fault_dly_q) || (stall_q && !stall_dly_q)) begin
      irq_d = 1'b1;
    end else if (clr_flt_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Interrupt register and edge-detect history.
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      irq_q       <= 1'b0;
      fault_dly_q <= 1'b0;
      stall_dly_q <= 1'b0;
    end else begin
      irq_q       <= irq_d;
      fault_dly_q <= fault_q;
      stall_dly_q <= stall_q;
    end
  end

  assign HALL_IRQ = irq_q;
  assign status_s = {irq_q, 15'h0000, serr_q, 1'b0, fcode_q, stall_q, dir_q, sector_q};
`else
  assign status_s = {16'h0000, serr_q, 1'b0, fcode_q, stall_q, dir_q, sector_q};
`endif

  // Read mux: combinational, zero unless a mapped register is being read.
  always_comb begin
    HALL_DO = 32'h0000_0000;
    if (LIFT_MOT_RE && sel_s) begin
      case (reg_idx_s)
        REG_POS:    HALL_DO = pos_q;
        REG_PERIOD: HALL_DO = period_q;
        REG_STATUS: HALL_DO = status_s;
        REG_CTRL:   HALL_DO = {31'h0000_0000, filter_en_q};
        default:    HALL_DO = 32'h0000_0000;
      endcase
    end else begin
      HALL_DO = 32'h0000_0000;
    end
  end

  assign HALL_SECTOR = sector_q;
  assign HALL_DIR    = dir_q;
  assign HALL_FAULT  = fault_q;

endmodule

// File: tb/tb_lift_hall_decoder.sv
// Self-checking bench for lift_hall_decoder: directed scenarios followed by a
// random sector walk, checked against a sector/position reference model.
module tb_lift_hall_decoder;

  localparam int        STALL   = 2000;
  localparam logic [2:0] ABASE  = 3'h4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hall_in = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] di = 32'h0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] hall_do;
  logic [2:0]  hall_sector;
  logic        hall_dir;
  logic        hall_fault;
`ifdef LIFT_HALL_IRQ_EN
  logic        hall_irq;
`endif

  lift_hall_decoder #(
    .FILT_LEN  (4),
    .STALL_MAX (32'(STALL)),
    .ADDR_BASE (ABASE)
  ) dut (
    .OPB_CLK     (clk),
    .OPB_RST     (rst),
    .HALL_IN     (hall_in),
    .LIFT_ADDR   (addr),
    .LIFT_MOT_DI (di),
    .LIFT_MOT_WE (we),
    .LIFT_MOT_RE (re),
    .HALL_DO     (hall_do),
    .HALL_SECTOR (hall_sector),
    .HALL_DIR    (hall_dir),
    .HALL_FAULT  (hall_fault)
`ifdef LIFT_HALL_IRQ_EN
    ,
    .HALL_IRQ    (hall_irq)
`endif
  );

  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Hall code table and its inverse, straight from the commutation table.
  logic [2:0] code_of [0:6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int         sec_of  [0:7] = '{0, 1, 3, 2, 5, 6, 4, 0};

  // Reference model state
  int         m_sector = 0;
  int         m_pos    = 0;
  bit         m_dir    = 1'b0;
  bit         m_fault  = 1'b0;
  logic [1:0] m_fcode  = 2'b00;
  int         m_serr   = 0;
  bit         m_stall  = 1'b0;
  bit         m_irq    = 1'b0;
  bit         m_filt   = 1'b1;
  int         m_period = 0;
  bit         m_period_known = 1'b1;
  int         last_evt = 0;
  bit         last_evt_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int step_sec(input int s, input int d);
    return ((s - 1 + d) % 6) + 1;
  endfunction

  // Apply the decoding rules to a newly presented (stable) code at cycle t.
  task automatic model_apply(input logic [2:0] c, input int t);
    int s, d, el;
    s = sec_of[c];
    if (s == 0) begin
      if (!m_fault) m_irq = 1'b1;
      m_fault = 1'b1;
      m_fcode = 2'b01;
    end else if (s != m_sector) begin
      if (last_evt_ok) begin
        el = t - last_evt - 1;
        if (el > STALL) el = STALL;
        m_period = el + 1;
        m_period_known = 1'b1;
      end else begin
        m_period_known = 1'b0;
      end
      last_evt = t;
      last_evt_ok = 1'b1;
      if (m_sector != 0) begin
        d = (s - m_sector + 6) % 6;
        if (d == 1) begin
          m_pos++; m_dir = 1'b1; m_stall = 1'b0;
        end else if (d == 5) begin
          m_pos--; m_dir = 1'b0; m_stall = 1'b0;
        end else begin
          if (!m_fault) m_irq = 1'b1;
          m_fault = 1'b1;
          m_fcode = 2'b10;
          if (m_serr < 255) m_serr++;
        end
      end
      m_sector = s;
    end
  endtask

  task automatic apply(input logic [2:0] c, input int hold);
    @(negedge clk);
    hall_in = c;
    model_apply(c, tb_cyc);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    addr = 32'(ABASE) + 32'(idx);
    re = 1'b1;
    #1;
    v = hall_do;
    re = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    @(negedge clk);
    addr = 32'(ABASE) + 32'd3;
    di = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    if (d[0]) m_pos = 0;
    if (d[1]) begin
      m_fault = 1'b0; m_fcode = 2'b00; m_serr = 0; m_irq = 1'b0;
    end
    if (m_filt != d[2]) last_evt_ok = 1'b0;
    m_filt = d[2];
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    logic        irq_bit;
`ifdef LIFT_HALL_IRQ_EN
    irq_bit = m_irq;
    check({tag, ".irq"}, 32'(hall_irq), 32'(m_irq));
`else
    irq_bit = 1'b0;
`endif
    check({tag, ".sector"}, 32'(hall_sector), 32'(m_sector));
    check({tag, ".dir"}, 32'(hall_dir), 32'(m_dir));
    check({tag, ".fault"}, 32'(hall_fault), 32'(m_fault));
    read_reg(0, v);
    check({tag, ".pos"}, v, 32'(m_pos));
    if (m_period_known) begin
      read_reg(1, v);
      check({tag, ".period"}, v, 32'(m_period));
    end
    read_reg(2, v);
    check({tag, ".status"}, v, {irq_bit, 15'h0, 8'(m_serr), 1'b0, m_fcode, m_stall, m_dir, 3'(m_sector)});
    read_reg(3, v);
    check({tag, ".ctrl"}, v, {31'h0, m_filt});
  endtask

  initial begin
    logic [31:0] v;
    int k, r, ns;

    // Reset
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");
    addr = 32'(ABASE);
    #1;
    check("noread", hall_do, 32'h0);
    addr = 32'h0000_0001;
    re = 1'b1;
    #1;
    check("unmapped", hall_do, 32'h0);
    re = 1'b0;

    // Full forward revolution
    for (int i = 0; i < 7; i++) apply(code_of[(i % 6) + 1], 20);
    check_all("fwd");
    check("fwd.pos6", 32'(m_pos), 32'd6);

    // Reverse steps from a cleared position
    ctrl_write(32'h5);
    apply(3'b001, 20);
    apply(3'b101, 20);
    apply(3'b100, 20);
    check_all("rev");
    read_reg(0, v);
    check("rev.minus2", v, 32'hFFFF_FFFE);

    // Skipped sectors
    apply(3'b001, 20);
    apply(3'b110, 20);
    check_all("jump");
    ctrl_write(32'h6);
    check_all("jump.clr");

    // Short glitch is rejected by the filter
    @(negedge clk);
    hall_in = 3'b100;
    repeat (3) @(negedge clk);
    hall_in = 3'b110;
    repeat (20) @(negedge clk);
    check_all("glitch.filt");

    // Same glitch without filtering: one step out and one back
    ctrl_write(32'h0);
    @(negedge clk);
    hall_in = 3'b100;
    model_apply(3'b100, tb_cyc);
    repeat (3) @(negedge clk);
    hall_in = 3'b110;
    model_apply(3'b110, tb_cyc);
    repeat (20) @(negedge clk);
    check_all("glitch.raw");
    ctrl_write(32'h4);

    // Fixed step spacing, then stall
    for (int i = 0; i < 3; i++) apply(code_of[step_sec(m_sector, 1)], 1000);
    check_all("period1000");
    apply(code_of[step_sec(m_sector, 1)], 1500);
    check_all("prestall");
    repeat (600) @(negedge clk);
    m_stall = 1'b1;
    m_irq = 1'b1;
    check_all("stall");
    apply(code_of[step_sec(m_sector, 1)], 20);
    check_all("stall.clr");

    // Invalid code
    ctrl_write(32'h6);
    @(negedge clk);
    hall_in = 3'b111;
    model_apply(3'b111, tb_cyc);
    k = 0;
    while (hall_fault !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("inv.fault_seen", 32'(hall_fault), 32'd1);
`ifdef LIFT_HALL_IRQ_EN
    check("inv.irq_lag", 32'(hall_irq), 32'd0);
    @(negedge clk);
    check("inv.irq_set", 32'(hall_irq), 32'd1);
`endif
    repeat (20) @(negedge clk);
    check_all("inv");
    ctrl_write(32'h6);
    check_all("inv.clr");
    apply(code_of[m_sector], 20);
    check_all("inv.restore");

    // Random walk
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 80) begin
        ns = step_sec(m_sector, ($urandom_range(0, 1) == 0) ? 1 : 5);
        apply(code_of[ns], $urandom_range(10, 60));
      end else if (r < 90) begin
        ns = step_sec(m_sector, $urandom_range(2, 4));
        apply(code_of[ns], $urandom_range(10, 60));
      end else begin
        apply(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111, $urandom_range(10, 60));
        ns = step_sec(m_sector, 1);
        apply(code_of[ns], $urandom_range(10, 60));
      end
      check_all("rand");
      if ($urandom_range(0, 9) == 0) ctrl_write(32'h6);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
